// File: rtl/cpu_run_ctrl.sv
// rtl/cpu_run_ctrl.sv - CPU run controller: reset sequencing, cycle budget, halt detect, optional PC trace (CPU_RUN_CTRL_TRACE_EN)
module cpu_run_ctrl #(
  parameter int PC_W         = 8,
  parameter int CNT_W        = 16,
  parameter int RESET_CYCLES = 2,
  parameter int MAX_CYCLES   = 100,
  parameter int TRACE_DEPTH  = 16,
  localparam int AW          = $clog2(TRACE_DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             cpu_halt,
  input  logic [PC_W-1:0]  cpu_pc,
  output logic             cpu_reset,
  output logic             running,
  output logic             done,
  output logic             timeout,
  output logic [CNT_W-1:0] cycle_count,
  input  logic [AW-1:0]    trace_raddr,
  output logic [PC_W-1:0]  trace_rdata,
  output logic [AW:0]      trace_count
);

  localparam int RW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RST  = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [RW-1:0]    rst_cnt_q, rst_cnt_d;
  logic [CNT_W-1:0] cycle_count_q, cycle_count_d;
  logic             timeout_q, timeout_d;
  logic             cpu_reset_q, cpu_reset_d;
  logic             running_q, running_d;
  logic             done_q, done_d;
  logic             trace_clr;

  // Next-state, counter and flag computation; outputs are decoded from the next state so they register cleanly
  always_comb begin
    state_d       = state_q;
    rst_cnt_d     = rst_cnt_q;
    cycle_count_d = cycle_count_q;
    timeout_d     = timeout_q;
    trace_clr     = 1'b0;
    case (state_q)
      S_IDLE: begin
        cycle_count_d = '0;
        timeout_d     = 1'b0;
        trace_clr     = 1'b1;
        rst_cnt_d     = '0;
        if (start) begin
          state_d = S_RST;
        end
      end
      S_RST: begin
        if (rst_cnt_q == RW'(RESET_CYCLES - 1)) begin
          state_d = S_RUN;
        end else begin
          rst_cnt_d = rst_cnt_q + RW'(1);
        end
      end
      S_RUN: begin
        cycle_count_d = cycle_count_q + CNT_W'(1);
        // Halt takes priority over budget exhaustion in the same cycle
        if (cpu_halt) begin
          state_d   = S_DONE;
          timeout_d = 1'b0;
        end else if (cycle_count_d == CNT_W'(MAX_CYCLES)) begin
          state_d   = S_DONE;
          timeout_d = 1'b1;
        end
      end
      S_DONE: begin
        if (start) begin
          state_d       = S_RST;
          rst_cnt_d     = '0;
          cycle_count_d = '0;
          timeout_d     = 1'b0;
          trace_clr     = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    cpu_reset_d = (state_d != S_RUN);
    running_d   = (state_d == S_RUN);
    done_d      = (state_d == S_DONE);
  end

  // State machine and registered control outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      rst_cnt_q     <= '0;
      cycle_count_q <= '0;
      timeout_q     <= 1'b0;
      cpu_reset_q   <= 1'b1;
      running_q     <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      rst_cnt_q     <= rst_cnt_d;
      cycle_count_q <= cycle_count_d;
      timeout_q     <= timeout_d;
      cpu_reset_q   <= cpu_reset_d;
      running_q     <= running_d;
      done_q        <= done_d;
    end
  end

  assign cpu_reset   = cpu_reset_q;
  assign running     = running_q;
  assign done        = done_q;
  assign timeout     = timeout_q;
  assign cycle_count = cycle_count_q;

`ifdef CPU_RUN_CTRL_TRACE_EN
  logic [PC_W-1:0] trace_mem [TRACE_DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]     tcount_q, tcount_d;
  logic [PC_W-1:0] last_pc_q, last_pc_d;
  logic [PC_W-1:0] trace_rdata_q, trace_rdata_d;
  logic [AW-1:0]   oldest, rd_idx;
  logic            trace_wr;

  // Record on the first RUN cycle of a run and whenever the PC moves
  assign trace_wr = (state_q == S_RUN) && ((tcount_q == '0) || (cpu_pc != last_pc_q));

  // Write pointer, fill level and read-address translation (raddr 0 is always the oldest entry)
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    tcount_d  = tcount_q;
    last_pc_d = last_pc_q;
    if (trace_clr) begin
      wr_ptr_d = '0;
      tcount_d = '0;
    end else if (trace_wr) begin
      wr_ptr_d  = wr_ptr_q + AW'(1);
      last_pc_d = cpu_pc;
      if (tcount_q != (AW+1)'(TRACE_DEPTH)) begin
        tcount_d = tcount_q + (AW+1)'(1);
      end
    end
    oldest        = (tcount_q == (AW+1)'(TRACE_DEPTH)) ? wr_ptr_q : '0;
    rd_idx        = oldest + trace_raddr;
    trace_rdata_d = trace_mem[rd_idx];
  end

  // Trace bookkeeping registers and registered read port
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q      <= '0;
      tcount_q      <= '0;
      last_pc_q     <= '0;
      trace_rdata_q <= '0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      tcount_q      <= tcount_d;
      last_pc_q     <= last_pc_d;
      trace_rdata_q <= trace_rdata_d;
    end
  end

  // Trace storage; contents need no reset because the fill level gates what is meaningful
  always_ff @(posedge clk) begin
    if (!reset && trace_wr && !trace_clr) begin
      trace_mem[wr_ptr_q] <= cpu_pc;
    end
  end

  assign trace_rdata = trace_rdata_q;
  assign trace_count = tcount_q;
`else
  logic unused_trace;
  assign unused_trace = ^{trace_raddr, cpu_pc, trace_clr};
  assign trace_rdata  = '0;
  assign trace_count  = '0;
`endif

endmodule

// File: doc/cpu_run_ctrl.md
# cpu_run_ctrl

Synthesizable run controller that sits between the simulation or board harness and `cpu_top`. It sequences the CPU's reset for a parametrised number of cycles and bounds execution with a cycle budget. It detects program completion through the CPU halt flag and, optionally, records a circular trace of program-counter values. This generalises the fixed "reset for one cycle, run 100 cycles" flow into a reusable, self-terminating block.

## Interface
- `PC_W`, default 8: width of the CPU program counter.
- `CNT_W`, default 16: width of the cycle counter.
- `RESET_CYCLES`, default 2: cycles `cpu_reset` is held high before run (≥1).
- `MAX_CYCLES`, default 100: run-cycle budget before timeout (1 … 2^CNT_W−1).
- `TRACE_DEPTH`, default 16: PC trace entries; power of two, ≥2.

Ports (direction, width, meaning):
- `clk`, in, 1: single clock; all logic is on the rising edge.
- `reset`, in, 1: synchronous, active-high; returns the block to IDLE.
- `start`, in, 1: single-cycle pulse that begins a run; honoured only in IDLE or DONE.
- `cpu_halt`, in, 1: CPU halt flag; sampled only in RUN.
- `cpu_pc`, in, PC_W: current CPU program counter.
- `cpu_reset`, out, 1: synchronous active-high reset to `cpu_top`.
- `running`, out, 1: high while in RUN.
- `done`, out, 1: high in DONE; sticky until the next `start` or `reset`.
- `timeout`, out, 1: qualifies `done`; 1 means the budget was exhausted without a halt.
- `cycle_count`, out, CNT_W: number of RUN cycles elapsed.
- `trace_raddr`, in, log2(TRACE_DEPTH): trace read index; 0 is the oldest entry.
- `trace_rdata`, out, PC_W: trace entry, registered.
- `trace_count`, out, log2(TRACE_DEPTH)+1: number of valid entries, saturating at TRACE_DEPTH.

## Operation
- The state machine has four states: IDLE, RST, RUN and DONE.
- **IDLE:** `cpu_reset`=1. When `start`=1 → RST.
  - Clear `cycle_count`, `done`, `timeout` and the trace.
- **RST:** `cpu_reset`=1. An internal counter runs from 0 to RESET_CYCLES−1, then → RUN. `start` is ignored.
- **RUN:** `cpu_reset`=0, `running`=1.
  - `cycle_count` increments every cycle.
  - If `cpu_halt`=1 → DONE with `timeout`=0.
  - Otherwise, if the incremented `cycle_count` equals MAX_CYCLES → DONE with `timeout`=1.
  - If halt and budget exhaustion occur in the same cycle, halt wins: `timeout`=0.
- **DONE:** `cpu_reset`=1 (freezes the CPU), `done`=1, and `cycle_count` holds.
  - `start`=1 → RST, clearing the counter, flags and trace exactly as from IDLE.
- **`reset` in any state:** → IDLE on the next edge and all outputs take their reset values, including mid-RST or mid-RUN.
- **Arithmetic:** `cycle_count` never exceeds MAX_CYCLES, so it cannot wrap.

## Timing
- **Reset values:** `cpu_reset`=1, `running`=0, `done`=0, `timeout`=0, `cycle_count`=0, `trace_count`=0, `trace_rdata`=0.
- **Start latency:** for `start` sampled at edge N:
  - `cpu_reset` stays 1 through edge N+RESET_CYCLES.
  - `cpu_reset` falls and `running` rises after edge N+RESET_CYCLES.
- **First run cycle:** `cycle_count` reads 1 after the first RUN edge.
- **Halt latency:** for `cpu_halt` sampled at RUN edge M:
  - `running` falls and `done` rises after edge M.
  - `cycle_count` includes cycle M.
- **Timeout:** `done` and `timeout` rise together after the edge at which `cycle_count` becomes MAX_CYCLES.
- **Trace read:** `trace_rdata` is valid one cycle after `trace_raddr` is applied. Reads are legal in any state.

## Configuration
- Macro: `CPU_RUN_CTRL_TRACE_EN`.
- **Defined:**
  - In RUN, each cycle in which `cpu_pc` differs from the last recorded value writes `cpu_pc` to a circular buffer. The first RUN cycle always records.
  - On wrap, the oldest entry is overwritten, and `trace_raddr`=0 still addresses the oldest surviving entry.
  - `trace_count` saturates at TRACE_DEPTH.
- **Undefined:**
  - No trace storage is built.
  - `trace_rdata`=0 and `trace_count`=0 permanently, and `trace_raddr` is ignored.
  - All other behaviour is identical.

## Test plan
Defaults apply unless stated otherwise (RESET_CYCLES=2, MAX_CYCLES=100, TRACE_DEPTH=16).
- **Reset state:** hold `reset` 3 cycles → `cpu_reset`=1, `done`=0, `cycle_count`=0. A `start` pulse → `cpu_reset` exactly 2 more cycles high, then `running`=1.
- **Halt:** raise `cpu_halt` on the 37th RUN cycle → `done`=1, `timeout`=0, `cycle_count`=37, `cpu_reset`=1 on the next cycle.
- **Timeout:** never halt → `done`=1, `timeout`=1, `cycle_count`=100. Assert `cpu_halt` exactly on cycle 100 → `timeout`=0.
- **Reset and start gating:** assert `reset` on RUN cycle 10 → IDLE next edge, all outputs at reset values. `start` pulsed during RST or RUN → no effect.
- **Restart:** after DONE, pulse `start` → `done`, `timeout` and `cycle_count` clear and a new RST phase begins.
- **Trace (CPU_RUN_CTRL_TRACE_EN):**
  - PC sequence 0,1,1,2,…,19 → `trace_count`=16.
  - `trace_raddr`=0 → `trace_rdata`=4; `trace_raddr`=15 → `trace_rdata`=19, each one cycle later.
  - Without the macro → reads 0.
